// File: rtl/conv_mc.sv
// conv_mc: multi-channel 2-D convolution, one multiply-accumulate tap per clock.
// For each output (filter f, row oy, column ox) the block walks c, ky, kx,
// accumulates feature*weight products, then presents the scaled, biased and
// saturated result on a valid/ready port. Taps that land in the zero border
// cost a cycle but add nothing.
// Optional build macro: CONV_MC_RELU_EN clamps negative results to zero.
module conv_mc #(
  parameter int N            = 16,
  parameter int Q            = 8,
  parameter int IMG_SIZE     = 8,
  parameter int K            = 3,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 4,
  parameter int STRIDE       = 1,
  parameter int PAD          = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [N*IN_CHANNELS*IMG_SIZE*IMG_SIZE-1:0] feat_flat,
  input  logic [N*OUT_CHANNELS*IN_CHANNELS*K*K-1:0]  weight_flat,
  input  logic [N*OUT_CHANNELS-1:0]                  bias_flat,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [N-1:0]                              out_data,
  output logic [15:0]                               out_ch,
  output logic [15:0]                               out_y,
  output logic [15:0]                               out_x,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam int OUT_SIDE = (IMG_SIZE + 2*PAD - K)/STRIDE + 1;
  localparam int ACC_W    = 2*N + 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              f_q, f_d, oy_q, oy_d, ox_q, ox_d;
  logic [15:0]              c_q, c_d, ky_q, ky_d, kx_q, kx_d;
  logic                     out_valid_q, out_valid_d;
  logic [N-1:0]             out_data_q, out_data_d;
  logic [15:0]              out_ch_q, out_ch_d, out_y_q, out_y_d, out_x_q, out_x_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  int                       tap_iy, tap_ix;
  int unsigned              feat_idx, wgt_idx;
  logic                     tap_in;
  logic signed [N-1:0]      feat_w, wgt_w, bias_w;
  logic signed [2*N-1:0]    prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     last_tap;

  // Scale, bias and saturate an accumulator into an N-bit output word.
  function automatic logic [N-1:0] finish_result(input logic signed [ACC_W-1:0] acc,
                                                 input logic signed [N-1:0]     bias);
    logic signed [ACC_W-1:0] sum;
    logic [N-1:0]            sat;
    sum = (acc >>> Q) + ACC_W'(bias);
    if (sum > SAT_MAX) begin
      sat = SAT_MAX[N-1:0];
    end else if (sum < SAT_MIN) begin
      sat = SAT_MIN[N-1:0];
    end else begin
      sat = sum[N-1:0];
    end
`ifdef CONV_MC_RELU_EN
    if (sat[N-1]) begin
      sat = '0;
    end
`endif
    return sat;
  endfunction

  // Current tap: input coordinate, border test, operand fetch and product.
  always_comb begin
    tap_iy   = int'(oy_q)*STRIDE + int'(ky_q) - PAD;
    tap_ix   = int'(ox_q)*STRIDE + int'(kx_q) - PAD;
    tap_in   = (tap_iy >= 0) && (tap_iy < IMG_SIZE) && (tap_ix >= 0) && (tap_ix < IMG_SIZE);
    feat_idx = '0;
    if (tap_in) begin
      feat_idx = unsigned'((int'(c_q)*IMG_SIZE + tap_iy)*IMG_SIZE + tap_ix);
    end
    wgt_idx  = unsigned'(((int'(f_q)*IN_CHANNELS + int'(c_q))*K + int'(ky_q))*K + int'(kx_q));
    feat_w   = N'(feat_flat >> (feat_idx*N));
    wgt_w    = N'(weight_flat >> (wgt_idx*N));
    bias_w   = N'(bias_flat >> (unsigned'(int'(f_q))*N));
    if (tap_in) begin
      prod = feat_w * wgt_w;
    end else begin
      prod = '0;
    end
    acc_sum  = acc_q + ACC_W'(prod);
    last_tap = (c_q == 16'(IN_CHANNELS-1)) && (ky_q == 16'(K-1)) && (kx_q == 16'(K-1));
  end

  // Next-state logic for the pass sequencer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    f_d         = f_q;
    oy_d        = oy_q;
    ox_d        = ox_q;
    c_d         = c_q;
    ky_d        = ky_q;
    kx_d        = kx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_y_d     = out_y_q;
    out_x_d     = out_x_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          f_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          c_d     = '0;
          ky_d    = '0;
          kx_d    = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (kx_q == 16'(K-1)) begin
          kx_d = '0;
          if (ky_q == 16'(K-1)) begin
            ky_d = '0;
            if (c_q == 16'(IN_CHANNELS-1)) begin
              c_d = '0;
            end else begin
              c_d = c_q + 16'd1;
            end
          end else begin
            ky_d = ky_q + 16'd1;
          end
        end else begin
          kx_d = kx_q + 16'd1;
        end
        // The result uses the sum including this final tap, so EMIT
        // presents it on the very next cycle.
        if (last_tap) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_data_d  = finish_result(acc_sum, bias_w);
          out_ch_d    = f_q;
          out_y_d     = oy_q;
          out_x_d     = ox_q;
          out_last_d  = (f_q == 16'(OUT_CHANNELS-1)) && (oy_q == 16'(OUT_SIDE-1)) &&
                        (ox_q == 16'(OUT_SIDE-1));
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          acc_d       = '0;
          if (out_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = MAC;
            if (ox_q == 16'(OUT_SIDE-1)) begin
              ox_d = '0;
              if (oy_q == 16'(OUT_SIDE-1)) begin
                oy_d = '0;
                f_d  = f_q + 16'd1;
              end else begin
                oy_d = oy_q + 16'd1;
              end
            end else begin
              ox_d = ox_q + 16'd1;
            end
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any pass in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      f_q         <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      c_q         <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_y_q     <= '0;
      out_x_q     <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      f_q         <= f_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      c_q         <= c_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_y_q     <= out_y_d;
      out_x_q     <= out_x_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_y     = out_y_q;
  assign out_x     = out_x_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_mc.sv
// tb_conv_mc: directed checks of conv_mc in three configurations
// (A: 4x4 no pad, B: 4x4 pad 1, C: 5x5 two channels stride 2).
module tb_conv_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt_a = 0;

  // Instance A: IMG 4, K 3, 1 in, 1 out, pad 0, stride 1
  logic         start_a = 1'b0, ready_a = 1'b0;
  logic [255:0] feat_a  = '0;
  logic [143:0] wgt_a   = '0;
  logic [15:0]  bias_a  = '0;
  logic         valid_a, last_a, busy_a, done_a;
  logic [15:0]  data_a, ch_a, y_a, x_a;

  // Instance B: as A with pad 1
  logic         start_b = 1'b0, ready_b = 1'b0;
  logic [255:0] feat_b  = '0;
  logic [143:0] wgt_b   = '0;
  logic [15:0]  bias_b  = '0;
  logic         valid_b, last_b, busy_b, done_b;
  logic [15:0]  data_b, ch_b, y_b, x_b;

  // Instance C: IMG 5, K 3, 2 in, 2 out, pad 0, stride 2
  logic         start_c = 1'b0, ready_c = 1'b0;
  logic [799:0] feat_c  = '0;
  logic [575:0] wgt_c   = '0;
  logic [31:0]  bias_c  = '0;
  logic         valid_c, last_c, busy_c, done_c;
  logic [15:0]  data_c, ch_c, y_c, x_c;

  conv_mc #(.N(16), .Q(8), .IMG_SIZE(4), .K(3), .IN_CHANNELS(1), .OUT_CHANNELS(1),
            .STRIDE(1), .PAD(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .feat_flat(feat_a), .weight_flat(wgt_a),
    .bias_flat(bias_a), .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .out_ch(ch_a), .out_y(y_a), .out_x(x_a), .out_last(last_a), .busy(busy_a), .done(done_a));

  conv_mc #(.N(16), .Q(8), .IMG_SIZE(4), .K(3), .IN_CHANNELS(1), .OUT_CHANNELS(1),
            .STRIDE(1), .PAD(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .feat_flat(feat_b), .weight_flat(wgt_b),
    .bias_flat(bias_b), .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .out_ch(ch_b), .out_y(y_b), .out_x(x_b), .out_last(last_b), .busy(busy_b), .done(done_b));

  conv_mc #(.N(16), .Q(8), .IMG_SIZE(5), .K(3), .IN_CHANNELS(2), .OUT_CHANNELS(2),
            .STRIDE(2), .PAD(0)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .feat_flat(feat_c), .weight_flat(wgt_c),
    .bias_flat(bias_c), .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c),
    .out_ch(ch_c), .out_y(y_c), .out_x(x_c), .out_last(last_c), .busy(busy_c), .done(done_c));

  always @(negedge clk) if (done_a) done_cnt_a++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic vsel(input int w);
    case (w)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  // All helpers are entered and left #1 after a rising edge.
  task automatic pulse_start(input int w);
    case (w)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Counts edges until out_valid; optionally pulses start on A mid-MAC.
  task automatic wait_valid(input int w, input bit poke, output int cyc);
    cyc = 0;
    while (!vsel(w) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start_a = poke && (cyc == 3);
    end
    start_a = 1'b0;
  endtask

  task automatic accept(input int w);
    case (w)
      0:       ready_a = 1'b1;
      1:       ready_b = 1'b1;
      default: ready_c = 1'b1;
    endcase
    @(posedge clk); #1;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
  endtask

  task automatic fill_a(input logic [15:0] fv, input logic [15:0] wv);
    for (int i = 0; i < 16; i++) feat_a[i*16 +: 16] = fv;
    for (int i = 0; i < 9; i++)  wgt_a[i*16 +: 16]  = wv;
  endtask

  task automatic run_pass_a(input string tag, input logic [15:0] exp, input int stall_idx,
                            input bit poke);
    int cyc;
    int d0;
    logic [15:0] ey, ex;
    logic el;
    d0 = done_cnt_a;
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(0, poke && (i == 1), cyc);
      ey = 16'(i / 2);
      ex = 16'(i % 2);
      el = (i == 3);
      check({tag, "_lat"}, 64'(cyc), 64'd9);
      check({tag, "_data"}, {48'd0, data_a}, {48'd0, exp});
      check({tag, "_pos"}, {15'd0, ch_a, y_a, x_a, last_a}, {15'd0, 16'd0, ey, ex, el});
      if (i == stall_idx) begin
        repeat (5) begin
          @(posedge clk); #1;
          check({tag, "_hold"}, {14'd0, valid_a, data_a, y_a, x_a, last_a},
                {14'd0, 1'b1, exp, ey, ex, el});
        end
      end
      accept(0);
      check({tag, "_accept"}, {63'd0, valid_a}, 64'd0);
    end
    check({tag, "_done_hi"}, {62'd0, done_a, busy_a}, 64'd3);
    @(posedge clk); #1;
    check({tag, "_done_lo"}, {62'd0, done_a, busy_a}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_cnt"}, 64'(done_cnt_a - d0), 64'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ctl"}, {60'd0, valid_a, last_a, busy_a, done_a}, 64'd0);
    check({tag, "_data"}, {48'd0, data_a}, 64'd0);
    check({tag, "_fields"}, {16'd0, ch_a, y_a, x_a}, 64'd0);
  endtask

  initial begin
    int cyc;
    int b;
    logic [15:0] exp;
    logic [15:0] neg_exp;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("rst");
    reset = 1'b0;

    // A: all 1.0 -> 9.0 per output; stray start mid-MAC is ignored
    fill_a(16'h0100, 16'h0100);
    bias_a = 16'h0000;
    run_pass_a("base", 16'h0900, -1, 1'b1);

    // A: consumer stalls on the second result for 5 cycles
    run_pass_a("stall", 16'h0900, 1, 1'b0);

    // A: positive overflow clamps to max
    fill_a(16'h7F00, 16'h7F00);
    run_pass_a("satp", 16'h7FFF, -1, 1'b0);

    // A: negative overflow clamps to min, or zero with ReLU
`ifdef CONV_MC_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    fill_a(16'h7F00, 16'h8100);
    run_pass_a("satn", neg_exp, -1, 1'b0);

    // A: reset mid-MAC, no resume, then a clean rerun
    fill_a(16'h0100, 16'h0100);
    pulse_start(0);
    repeat (4) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1 check_reset_a("rst_mac");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("rst_noresume", {62'd0, busy_a, valid_a}, 64'd0);
    run_pass_a("rerun", 16'h0900, -1, 1'b0);

    // A: reset while a result is held in EMIT
    pulse_start(0);
    wait_valid(0, 1'b0, cyc);
    check("emit_pre", {63'd0, valid_a}, 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_a("rst_emit");
    @(posedge clk); #1;
    reset = 1'b0;

    // B: pad 1 -> corners 4.0, edges 6.0, centre 9.0
    for (int i = 0; i < 16; i++) feat_b[i*16 +: 16] = 16'h0100;
    for (int i = 0; i < 9; i++)  wgt_b[i*16 +: 16]  = 16'h0100;
    pulse_start(1);
    for (int i = 0; i < 16; i++) begin
      int oy, ox;
      oy = i / 4;
      ox = i % 4;
      b = int'(oy == 0 || oy == 3) + int'(ox == 0 || ox == 3);
      exp = (b == 2) ? 16'h0400 : (b == 1) ? 16'h0600 : 16'h0900;
      wait_valid(1, 1'b0, cyc);
      check("pad_lat", 64'(cyc), 64'd9);
      check("pad_data", {48'd0, data_b}, {48'd0, exp});
      check("pad_pos", {15'd0, y_b, x_b, last_b}, {15'd0, 16'(oy), 16'(ox), (i == 15)});
      accept(1);
    end
    check("pad_done", {63'd0, done_b}, 64'd1);
    @(posedge clk); #1;

    // C: two passes; second has column x=4 set to 2.0 in both channels
    for (int pass = 0; pass < 2; pass++) begin
      logic [15:0] e [2][2];
      for (int c = 0; c < 2; c++)
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++)
            feat_c[(c*25 + y*5 + x)*16 +: 16] = (pass == 1 && x == 4) ? 16'h0200 : 16'h0100;
      for (int i = 0; i < 18; i++) wgt_c[i*16 +: 16]      = 16'h0100;
      for (int i = 18; i < 36; i++) wgt_c[i*16 +: 16]     = 16'h0200;
      bias_c = {16'h0100, 16'h0080};
      e[0][0] = 16'h1280;
      e[0][1] = (pass == 1) ? 16'h1880 : 16'h1280;
      e[1][0] = 16'h2500;
      e[1][1] = (pass == 1) ? 16'h3100 : 16'h2500;
      pulse_start(2);
      for (int i = 0; i < 8; i++) begin
        int f, oy, ox;
        f  = i / 4;
        oy = (i / 2) % 2;
        ox = i % 2;
        wait_valid(2, 1'b0, cyc);
        check("str_lat", 64'(cyc), 64'd18);
        check("str_data", {48'd0, data_c}, {48'd0, e[f][ox]});
        check("str_pos", {15'd0, ch_c, y_c, x_c, last_c},
              {15'd0, 16'(f), 16'(oy), 16'(ox), (i == 7)});
        accept(2);
      end
      check("str_done", {63'd0, done_c}, 64'd1);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mc.md
CONV_MC -- requirements
Module: conv_mc

Interface
REQ-001 SHALL have parameter N, default 16, signed fixed-point data width.
REQ-002 SHALL have parameter Q, default 8, fractional bits.
REQ-003 SHALL have parameter IMG_SIZE, default 8, input height and width.
REQ-004 SHALL have parameter K, default 3, kernel side.
REQ-005 SHALL have parameter IN_CHANNELS, default 2, input feature-map count.
REQ-006 SHALL have parameter OUT_CHANNELS, default 4, filter count.
REQ-007 SHALL have parameter STRIDE, default 1, step in pixels, range 1..K.
REQ-008 SHALL have parameter PAD, default 0, zero border on each side, range 0..K-1.
REQ-009 SHALL derive OUT_SIDE = (IMG_SIZE + 2*PAD - K)/STRIDE + 1 and ACC_W = 2*N + 16.
REQ-010 Ports, one per line (name, direction, width, meaning):
 clk  input  1  clock
 reset  input  1  asynchronous, active-high reset
 start  input  1  begin a layer pass, sampled only in IDLE
 feat_flat  input  N*IN_CHANNELS*IMG_SIZE*IMG_SIZE  element (c,y,x) at index c*IMG_SIZE^2 + y*IMG_SIZE + x
 weight_flat  input  N*OUT_CHANNELS*IN_CHANNELS*K*K  element (f,c,ky,kx) at ((f*IN_CHANNELS + c)*K + ky)*K + kx
 bias_flat  input  N*OUT_CHANNELS  bias of filter f at index f
 out_valid  output  1  out_data holds a result
 out_ready  input  1  consumer accepts the result
 out_data  output  N  saturated result
 out_ch  output  16  filter index of out_data
 out_y  output  16  output row
 out_x  output  16  output column
 out_last  output  1  marks the final result of the pass
 busy  output  1  high in any state except IDLE
 done  output  1  one-cycle pulse at the end of the pass

Function
REQ-011 SHALL implement states IDLE, MAC, EMIT and DONE.
REQ-012 IDLE with start=1 SHALL clear acc, f, oy, ox, c, ky and kx, then enter MAC on the next edge.
REQ-013 MAC SHALL accumulate one tap per cycle, in order c (outer), ky, kx (inner), so each output takes IN_CHANNELS*K*K cycles.
REQ-014 Tap input coordinate: iy = oy*STRIDE + ky - PAD and ix = ox*STRIDE + kx - PAD; a tap with iy or ix outside 0..IMG_SIZE-1 SHALL contribute zero and still take one cycle.
REQ-015 Product SHALL be a 2N-bit signed multiply, sign-extended into an ACC_W-bit accumulator.
REQ-016 After the last tap the block SHALL enter EMIT, with out_data = sat_N((acc >>> Q) + sign-extended bias[f]).
REQ-017 sat_N SHALL clamp to 2^(N-1)-1 and -2^(N-1); the shift SHALL be arithmetic.
REQ-018 In EMIT, out_valid SHALL be 1; out_data, out_ch, out_y, out_x and out_last SHALL stay stable until out_valid and out_ready are both high on the same edge.
REQ-019 On that handshake, ox SHALL advance, then oy, then f; acc SHALL be cleared and the state SHALL return to MAC.
REQ-020 If the accepted result has out_last=1, the state SHALL go to DONE instead of MAC.
REQ-021 out_last SHALL be 1 only for f=OUT_CHANNELS-1, oy=OUT_SIDE-1, ox=OUT_SIDE-1.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE; a new pass may start from IDLE.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 feat_flat, weight_flat and bias_flat SHALL be held stable by the source while busy=1; behaviour otherwise is undefined.
REQ-025 out_valid SHALL be 0 in IDLE, MAC and DONE.

Reset
REQ-026 reset SHALL act immediately at any time, including mid-MAC or in EMIT with out_valid held.
REQ-027 On reset the block SHALL enter IDLE, clear all counters and acc, and drive out_valid=0, out_data=0, out_ch=0, out_y=0, out_x=0, out_last=0, busy=0 and done=0.
REQ-028 A pass interrupted by reset SHALL NOT resume; a new start is required.

Configuration
REQ-029 When macro CONV_MC_RELU_EN is defined, out_data SHALL be max(0, sat_N(...)); negative results SHALL be emitted as 0.
REQ-030 When CONV_MC_RELU_EN is not defined, out_data SHALL be the signed saturated value, and no ReLU logic SHALL be present.

Verification
REQ-031 IMG_SIZE=4, K=3, IN_CHANNELS=1, OUT_CHANNELS=1, PAD=0, STRIDE=1; all features 0x0100 (1.0); all weights 0x0100; bias 0 -> four results 0x0900 in order (0,0),(0,1),(1,0),(1,1), each 9 cycles after the previous handshake with out_ready=1; out_last only on the 4th; done pulses once.
REQ-032 Same configuration with PAD=1 -> 16 outputs; corner outputs 0x0400, edge outputs 0x0600, centre outputs 0x0900.
REQ-033 IN_CHANNELS=2, STRIDE=2, IMG_SIZE=5, PAD=0 -> OUT_SIDE=2; output (0,1) reads ix 2..4 of both channels; with all values 1.0 and bias 0x0080, result 0x1280.
REQ-034 Features 0x7F00, weights 0x7F00, K=3 -> out_data=0x7FFF; with negated weights -> 0x8000 without CONV_MC_RELU_EN, 0x0000 with it.
REQ-035 out_ready held low for 5 cycles in EMIT -> out_valid and all output fields stable for 5 cycles; no counter advances.
REQ-036 reset asserted mid-MAC, then start again -> all outputs at reset values; the full result sequence repeats from (0,0,0) and matches a run without reset.
